// File: rtl/xadc_drp_scheduler.sv
// XADC DRP read sequencer for a two-axis joystick: alternates X/Y reads on eoc,
// watchdogs the drdy handshake and publishes raw samples plus deadband directions.
module xadc_drp_scheduler #(
  parameter logic [6:0] X_ADDR   = 7'h16,
  parameter logic [6:0] Y_ADDR   = 7'h17,
  parameter int         TIMEOUT  = 255,
  parameter logic [3:0] HI_TH    = 4'd12,
  parameter logic [3:0] LO_TH    = 4'd3,
  parameter bit         INVERT_Y = 1'b1
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        i_eoc,
  input  logic        i_hold,
  output logic        o_den,
  output logic [6:0]  o_daddr,
  input  logic        i_drdy,
  input  logic [15:0] i_do,
  output logic [11:0] o_x_raw,
  output logic [11:0] o_y_raw,
  output logic [1:0]  o_x_dir,
  output logic [1:0]  o_y_dir,
  output logic        o_sample_valid,
  output logic        o_timeout,
  output logic [7:0]  o_err_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t      state_q;
  logic        ch_q;          // 0 = X channel, 1 = Y channel
  logic [7:0]  wd_q;
  logic [7:0]  wd_d;
  logic        den_q;
  logic [6:0]  daddr_q;
  logic [11:0] x_raw_q;
  logic [11:0] y_raw_q;
  logic [1:0]  x_dir_q;
  logic [1:0]  y_dir_q;
  logic [1:0]  dir_d;
  logic        sv_q;
  logic        tmo_q;
  logic [7:0]  err_q;
  logic        unused_do_lsbs;

  // Upper nibble against thresholds; swap maps positive<->negative.
  function automatic logic [1:0] decode_dir(input logic [3:0] u, input logic swap);
    logic [1:0] d;
    if (u >= HI_TH)      d = 2'd1;
    else if (u <= LO_TH) d = 2'd2;
    else                 d = 2'd0;
    if (swap && d != 2'd0) d = ~d;
    return d;
  endfunction

  assign unused_do_lsbs = ^i_do[3:0];

  always_comb begin
    wd_d  = wd_q + 8'd1;
    dir_d = decode_dir(i_do[15:12], ch_q & INVERT_Y);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= 1'b0;
      wd_q    <= 8'd0;
      den_q   <= 1'b0;
      daddr_q <= X_ADDR;
      x_raw_q <= 12'd0;
      y_raw_q <= 12'd0;
      x_dir_q <= 2'd0;
      y_dir_q <= 2'd0;
      sv_q    <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      den_q <= 1'b0;
      sv_q  <= 1'b0;
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_eoc && !i_hold) begin
            state_q <= REQ;
            den_q   <= 1'b1;
            daddr_q <= ch_q ? Y_ADDR : X_ADDR;
          end
        end
        REQ: begin
          wd_q    <= 8'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          // drdy takes priority over a watchdog expiry on the same edge
          if (i_drdy) begin
            if (ch_q) begin
              y_raw_q <= i_do[15:4];
              y_dir_q <= dir_d;
              sv_q    <= 1'b1;
            end else begin
              x_raw_q <= i_do[15:4];
              x_dir_q <= dir_d;
            end
            ch_q    <= ~ch_q;
            state_q <= IDLE;
          end else if (wd_d == TO_LIM) begin
            tmo_q   <= 1'b1;
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_den          = den_q;
  assign o_daddr        = daddr_q;
  assign o_x_raw        = x_raw_q;
  assign o_y_raw        = y_raw_q;
  assign o_x_dir        = x_dir_q;
  assign o_y_dir        = y_dir_q;
  assign o_sample_valid = sv_q;
  assign o_timeout      = tmo_q;
  assign o_err_cnt      = err_q;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Self-checking bench for xadc_drp_scheduler against a transaction-level model.
module tb_xadc_drp_scheduler;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        eoc = 1'b0;
  logic        hold = 1'b0;
  logic        drdy = 1'b0;
  logic [15:0] din = 16'h0;
  logic        den;
  logic [6:0]  daddr;
  logic [11:0] x_raw, y_raw;
  logic [1:0]  x_dir, y_dir;
  logic        sv, tmo;
  logic [7:0]  err;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the outputs should currently hold.
  bit         m_ch;
  logic [6:0] m_addr;
  logic [11:0] m_x, m_y;
  logic [1:0] m_xd, m_yd;
  int         m_err;

  xadc_drp_scheduler #(.TIMEOUT(TO)) dut (
    .CLK100MHZ(clk), .reset(reset), .i_eoc(eoc), .i_hold(hold),
    .o_den(den), .o_daddr(daddr), .i_drdy(drdy), .i_do(din),
    .o_x_raw(x_raw), .o_y_raw(y_raw), .o_x_dir(x_dir), .o_y_dir(y_dir),
    .o_sample_valid(sv), .o_timeout(tmo), .o_err_cnt(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_dir(input logic [15:0] d, input bit is_y);
    int u;
    int r;
    u = int'(d[15:12]);
    if (u >= 12)     r = 1;
    else if (u <= 3) r = 2;
    else             r = 0;
    if (is_y && r == 1)      r = 2;
    else if (is_y && r == 2) r = 1;
    return 2'(r);
  endfunction

  task automatic model_reset();
    m_ch = 0; m_addr = 7'h16; m_x = 0; m_y = 0; m_xd = 0; m_yd = 0; m_err = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_x_raw"}, x_raw, m_x);
    check({tag, "_y_raw"}, y_raw, m_y);
    check({tag, "_x_dir"}, x_dir, m_xd);
    check({tag, "_y_dir"}, y_dir, m_yd);
    check({tag, "_err"},   err,   m_err);
    check({tag, "_daddr"}, daddr, m_addr);
    check({tag, "_den"},   den,   0);
    check({tag, "_sv"},    sv,    0);
    check({tag, "_tmo"},   tmo,   0);
  endtask

  // Start a read on eoc; drdy is sampled lat edges after the den-raising edge.
  task automatic do_read(input logic [15:0] d, input int lat);
    bit was_y;
    @(negedge clk); eoc = 1'b1; hold = 1'b0;
    @(negedge clk); eoc = 1'b0;
    m_addr = m_ch ? 7'h17 : 7'h16;
    check("den_pulse", den, 1);
    check("den_daddr", daddr, m_addr);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      eoc = 1'($urandom_range(0, 1));
      check("den_single", den, 0);
      check("no_early_tmo", tmo, 0);
    end
    drdy = 1'b1; eoc = 1'b0; din = d;
    @(negedge clk);
    drdy = 1'b0; din = 16'($urandom);
    was_y = m_ch;
    if (was_y) begin m_y = d[15:4]; m_yd = ref_dir(d, 1); end
    else       begin m_x = d[15:4]; m_xd = ref_dir(d, 0); end
    m_ch = ~m_ch;
    check("rd_x_raw", x_raw, m_x);
    check("rd_y_raw", y_raw, m_y);
    check("rd_x_dir", x_dir, m_xd);
    check("rd_y_dir", y_dir, m_yd);
    check("rd_sv", sv, was_y);
    check("rd_tmo", tmo, 0);
    check("rd_err", err, m_err);
    @(negedge clk);
    check("sv_one_cycle", sv, 0);
  endtask

  task automatic do_timeout();
    int n;
    bit seen;
    @(negedge clk); eoc = 1'b1; hold = 1'b0;
    @(negedge clk); eoc = 1'b0;
    m_addr = m_ch ? 7'h17 : 7'h16;
    check("to_den", den, 1);
    check("to_daddr", daddr, m_addr);
    n = 0; seen = 0;
    while (!seen && n < TO + 20) begin
      @(negedge clk);
      n++;
      if (tmo) seen = 1;
    end
    check("to_seen", seen, 1);
    check("to_latency", n, TO + 1);
    if (m_err != 255) m_err++;
    check("to_err_cnt", err, m_err);
    @(negedge clk);
    check("to_one_cycle", tmo, 0);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all("reset");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_no_den", den, 0);
    end

    // Normal X then Y
    do_read(16'hF230, 3);
    check("x_raw_F23", x_raw, 12'hF23);
    check("x_dir_pos", x_dir, 1);
    do_read(16'h1000, 3);
    check("y_raw_100", y_raw, 12'h100);
    check("y_dir_inv", y_dir, 1);

    // Deadband
    do_read(16'h8000, 2);
    check("x_dir_dead", x_dir, 0);
    do_read(16'hC000, 2);
    check("y_dir_hi_inv", y_dir, 2);
    do_read(16'h3FF0, 2);
    check("x_dir_neg", x_dir, 2);
    do_read(16'h4000, 2);

    // Timeout then retry on the same channel
    do_timeout();
    check("err_one", err, 1);
    do_read(16'hBEEF, 4);

    // drdy on the exact expiry edge wins
    do_read(16'h2220, TO + 1);
    do_read(16'hD550, TO);

    // Hold suppresses eoc
    @(negedge clk); hold = 1'b1; eoc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_no_den", den, 0);
    end
    eoc = 1'b0; hold = 1'b0;

    // drdy in IDLE changes nothing
    @(negedge clk); drdy = 1'b1; din = 16'h7770;
    @(negedge clk); drdy = 1'b0;
    check_all("idle_drdy");

    // Randomized reads
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) do_timeout();
      else do_read(16'($urandom), int'($urandom_range(2, TO + 1)));
    end
    check_all("after_rand");

    // Reset mid Y transaction
    if (m_ch) do_read(16'h5550, 2);
    do_read(16'hE000, 2);
    @(negedge clk); eoc = 1'b1;
    @(negedge clk); eoc = 1'b0;
    check("mid_den", den, 1);
    check("mid_daddr_y", daddr, 7'h17);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; drdy = 1'b1; din = 16'hF000;
    model_reset();
    @(negedge clk); drdy = 1'b0;
    check_all("mid_reset");
    do_read(16'h9990, 3);

    // Saturation
    for (int k = 0; k < 300; k++) do_timeout();
    check("err_saturated", err, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
